draw_arbiter: RTL and testbench

Shares the single pixel-write port of the VGA adapter (160×120 frame, 3-bit colour) between up to four drawing engines: the UI line drawer, sprites, score and similar. Arbitration is round-robin. A grant is held until the owning engine signals completion. The block also contains a built-in full-screen clear sweep, which has priority over all engines at the next idle point. It sits between the game-state controller / drawing engines and the VGA adapter.

---
 rtl/draw_pkg.sv | 13 +
 rtl/draw_rr_pick.sv | 25 ++
 rtl/draw_arbiter.sv | 176 +++++++++++++++++
 tb/tb_draw_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared defaults and FSM encoding for the draw-port arbiter.
package draw_pkg;
    localparam int DRAW_N_REQ    = 4;
    localparam int DRAW_X_MAX    = 159;
    localparam int DRAW_Y_MAX    = 119;
    localparam int DRAW_COLOUR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CLEAR = 2'd2
    } state_t;
endpackage

// File: rtl/draw_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
module draw_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_pick,
    output logic             o_valid
);
    logic [PW-1:0] w_idx;

    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/draw_arbiter.sv
// Shares the VGA pixel-write port between drawing engines (round-robin,
// grant held until done) with a built-in full-screen clear sweep.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int N_REQ    = DRAW_N_REQ,
    parameter int X_MAX    = DRAW_X_MAX,
    parameter int Y_MAX    = DRAW_Y_MAX,
    parameter int COLOUR_W = DRAW_COLOUR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             done,
    input  logic [8*N_REQ-1:0]           x_in,
    input  logic [7*N_REQ-1:0]           y_in,
    input  logic [COLOUR_W*N_REQ-1:0]    colour_in,
    input  logic [N_REQ-1:0]             plot_in,
    input  logic                         clear_req,
    input  logic [COLOUR_W-1:0]          clear_colour,
    output logic [N_REQ-1:0]             gnt,
    output logic [7:0]                   x_out,
    output logic [6:0]                   y_out,
    output logic [COLOUR_W-1:0]          colour_out,
    output logic                         plot_out,
    output logic                         busy,
    output logic                         clear_done
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                r_state, w_state_nx;
    logic [PW-1:0]         r_rr_ptr, w_rr_ptr_nx;
    logic [PW-1:0]         r_owner, w_owner_nx;
    logic                  r_clear_pend, w_clear_pend_nx;
    logic [COLOUR_W-1:0]   r_pend_colour, w_pend_colour_nx;
    logic [COLOUR_W-1:0]   r_clr_colour, w_clr_colour_nx;
    logic [7:0]            r_sx, w_sx_nx;
    logic [6:0]            r_sy, w_sy_nx;
    logic                  r_sweep_end, w_sweep_end_nx;

    logic [N_REQ-1:0]      w_gnt_nx;
    logic [7:0]            w_x_nx;
    logic [6:0]            w_y_nx;
    logic [COLOUR_W-1:0]   w_colour_nx;
    logic                  w_plot_nx, w_busy_nx, w_clear_done_nx;

    logic [N_REQ-1:0]      w_pick;
    logic                  w_pick_vld;
    logic [PW-1:0]         w_pick_idx;

    draw_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_vld)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (w_pick[i]) w_pick_idx = PW'(i);
    end

    always_comb begin
        w_state_nx       = r_state;
        w_rr_ptr_nx      = r_rr_ptr;
        w_owner_nx       = r_owner;
        w_clear_pend_nx  = r_clear_pend;
        w_pend_colour_nx = r_pend_colour;
        w_clr_colour_nx  = r_clr_colour;
        w_sx_nx          = r_sx;
        w_sy_nx          = r_sy;
        w_sweep_end_nx   = r_sweep_end;
        w_gnt_nx         = gnt;
        w_x_nx           = x_out;
        w_y_nx           = y_out;
        w_colour_nx      = colour_out;
        w_plot_nx        = 1'b0;
        w_clear_done_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                if (clear_req || r_clear_pend) begin
                    // A fresh pulse this cycle carries the newest colour.
                    w_state_nx      = CLEAR;
                    w_clear_pend_nx = 1'b0;
                    w_clr_colour_nx = clear_req ? clear_colour : r_pend_colour;
                    w_sx_nx         = '0;
                    w_sy_nx         = '0;
                    w_sweep_end_nx  = 1'b0;
                    w_gnt_nx        = '0;
                end else if (w_pick_vld) begin
                    w_state_nx = GRANT;
                    w_gnt_nx   = w_pick;
                    w_owner_nx = w_pick_idx;
                end
            end
            GRANT: begin
                w_x_nx      = x_in[int'(r_owner)*8 +: 8];
                w_y_nx      = y_in[int'(r_owner)*7 +: 7];
                w_colour_nx = colour_in[int'(r_owner)*COLOUR_W +: COLOUR_W];
                w_plot_nx   = plot_in[r_owner];
                if (done[r_owner] || !req[r_owner]) begin
                    w_state_nx  = IDLE;
                    w_gnt_nx    = '0;
                    w_rr_ptr_nx = (r_owner == PW'(N_REQ-1)) ? '0 : r_owner + PW'(1);
                end
            end
            CLEAR: begin
                // One extra cycle after the last pixel carries clear_done.
                if (r_sweep_end) begin
                    w_state_nx      = IDLE;
                    w_clear_done_nx = 1'b1;
                end else begin
                    w_x_nx      = r_sx;
                    w_y_nx      = r_sy;
                    w_colour_nx = r_clr_colour;
                    w_plot_nx   = 1'b1;
                    if (r_sx == 8'(X_MAX)) begin
                        w_sx_nx = '0;
                        if (r_sy == 7'(Y_MAX)) w_sweep_end_nx = 1'b1;
                        else                   w_sy_nx = r_sy + 7'd1;
                    end else begin
                        w_sx_nx = r_sx + 8'd1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        if (clear_req && r_state != IDLE) begin
            w_clear_pend_nx  = 1'b1;
            w_pend_colour_nx = clear_colour;
        end

        w_busy_nx = (w_state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_clear_pend  <= 1'b0;
            r_pend_colour <= '0;
            r_clr_colour  <= '0;
            r_sx          <= '0;
            r_sy          <= '0;
            r_sweep_end   <= 1'b0;
            gnt           <= '0;
            x_out         <= '0;
            y_out         <= '0;
            colour_out    <= '0;
            plot_out      <= 1'b0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_rr_ptr      <= w_rr_ptr_nx;
            r_owner       <= w_owner_nx;
            r_clear_pend  <= w_clear_pend_nx;
            r_pend_colour <= w_pend_colour_nx;
            r_clr_colour  <= w_clr_colour_nx;
            r_sx          <= w_sx_nx;
            r_sy          <= w_sy_nx;
            r_sweep_end   <= w_sweep_end_nx;
            gnt           <= w_gnt_nx;
            x_out         <= w_x_nx;
            y_out         <= w_y_nx;
            colour_out    <= w_colour_nx;
            plot_out      <= w_plot_nx;
            busy          <= w_busy_nx;
            clear_done    <= w_clear_done_nx;
        end
    end
endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench: a transaction-level model queues expected status and
// pixel writes each edge; a negedge monitor pops and compares.
module tb_draw_arbiter;
    localparam int N = 4;
    localparam int CW = 3;
    localparam int FRAME = 160 * 120;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0, done = '0, plot_in = '0;
    logic [8*N-1:0]  x_in = '0;
    logic [7*N-1:0]  y_in = '0;
    logic [CW*N-1:0] colour_in = '0;
    logic            clear_req = 1'b0;
    logic [CW-1:0]   clear_colour = '0;
    logic [N-1:0]    gnt;
    logic [7:0]      x_out;
    logic [6:0]      y_out;
    logic [CW-1:0]   colour_out;
    logic            plot_out, busy, clear_done;

    draw_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
        .clear_req(clear_req), .clear_colour(clear_colour),
        .gnt(gnt), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot_out(plot_out), .busy(busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [N-1:0] gnt; logic busy; logic cdone; logic plot; } st_t;
    typedef struct packed { logic [7:0] x; logic [6:0] y; logic [CW-1:0] c; } pix_t;

    st_t  st_q[$];
    pix_t pix_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 granted to m_own, 2 sweeping pixel index m_k.
    int          m_mode = 0, m_own = 0, m_ptr = 0, m_k = 0;
    bit          m_pend = 0;
    logic [CW-1:0] m_pcol = '0, m_ccol = '0;

    always @(posedge clk or posedge reset) begin
        st_t  e;
        pix_t p;
        bit   pend_in;
        e = '0;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_pend = 0; m_k = 0;
            st_q.delete();
            pix_q.delete();
            st_q.push_back(e);
        end else begin
            pend_in = clear_req && (m_mode != 0);
            case (m_mode)
                0: begin
                    if (clear_req || m_pend) begin
                        m_ccol = clear_req ? clear_colour : m_pcol;
                        m_pend = 0;
                        m_mode = 2;
                        m_k    = 0;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            int j;
                            j = (m_ptr + i) % N;
                            if (m_mode == 0 && req[j]) begin
                                m_own  = j;
                                m_mode = 1;
                            end
                        end
                    end
                end
                1: begin
                    e.plot = plot_in[m_own];
                    if (e.plot) begin
                        p.x = x_in[m_own*8 +: 8];
                        p.y = y_in[m_own*7 +: 7];
                        p.c = colour_in[m_own*CW +: CW];
                        pix_q.push_back(p);
                    end
                    if (done[m_own] || !req[m_own]) begin
                        m_ptr  = (m_own + 1) % N;
                        m_mode = 0;
                    end
                end
                default: begin
                    if (m_k == FRAME) begin
                        e.cdone = 1'b1;
                        m_mode  = 0;
                    end else begin
                        e.plot = 1'b1;
                        p.x = 8'(m_k % 160);
                        p.y = 7'(m_k / 160);
                        p.c = m_ccol;
                        pix_q.push_back(p);
                        m_k++;
                    end
                end
            endcase
            if (pend_in) begin
                m_pend = 1;
                m_pcol = clear_colour;
            end
            e.gnt  = (m_mode == 1) ? N'(1 << m_own) : '0;
            e.busy = (m_mode != 0);
            st_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        st_t  e;
        pix_t p;
        if (st_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL status_queue: got empty want entry at %0t", $time);
        end else begin
            e = st_q.pop_front();
            if (!reset) begin
                chk("status{gnt,busy,cdone,plot}", 32'({gnt, busy, clear_done, plot_out}), 32'(e));
                if (plot_out) begin
                    if (pix_q.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL pixel_queue: got plot (%0d,%0d) want none", x_out, y_out);
                    end else begin
                        p = pix_q.pop_front();
                        chk("pixel{x,y,colour}", 32'({x_out, y_out, colour_out}), 32'(p));
                    end
                end
            end
        end
    end

    int cnt[N];

    // One cycle of engine behaviour; called right after a negedge.
    task automatic step_engines(input bit rnd, input int lim, input bit keep_req);
        x_in      = $urandom;
        y_in      = 28'($urandom);
        colour_in = 12'($urandom);
        plot_in   = 4'($urandom);
        for (int i = 0; i < N; i++) begin
            done[i] = 1'b0;
            if (gnt[i]) begin
                if (rnd ? ($urandom_range(3) == 0) : (cnt[i] >= lim)) begin
                    done[i] = 1'b1;
                    cnt[i]  = 0;
                    req[i]  = rnd ? 1'($urandom_range(1)) : keep_req;
                end else begin
                    cnt[i]++;
                    if (rnd && $urandom_range(15) == 0) req[i] = 1'b0;
                end
            end else begin
                cnt[i] = 0;
                if (rnd) begin
                    if (!req[i] && $urandom_range(3) == 0) req[i] = 1'b1;
                    if ($urandom_range(7) == 0) done[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_xy"}, 32'({x_out, y_out}), 0);
        chk({tag, "_colour"}, 32'(colour_out), 0);
        chk({tag, "_plot_busy_cdone"}, 32'({plot_out, busy, clear_done}), 0);
    endtask

    initial begin
        int  seen;
        bit  hit;
        for (int i = 0; i < N; i++) cnt[i] = 0;

        // Reset with engines 0 and 2 requesting.
        req = 4'b0101;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset_hold");
        #1 reset = 1'b0;
        repeat (20) begin @(negedge clk); step_engines(0, 2, 0); end

        // All four requesting continuously, done after 3 pixels.
        @(negedge clk); req = 4'b1111;
        repeat (45) begin @(negedge clk); step_engines(0, 3, 1); end
        @(negedge clk); req = '0; done = '0;
        repeat (3) @(negedge clk);

        // Clear requested while engine 0 holds the grant.
        req = 4'b0001;
        hit = 0;
        for (int c = 0; c < 10 && !hit; c++) begin @(negedge clk); hit = gnt[0]; end
        if (!hit) begin n_vec++; n_bad++; $display("FAIL grant0_timeout: got no grant want gnt[0]"); end
        clear_req = 1'b1; clear_colour = 3'b010;
        @(negedge clk); clear_req = 1'b0; clear_colour = 3'b000;
        repeat (4) begin @(negedge clk); x_in = $urandom; plot_in = 4'($urandom); end
        done = 4'b0001; req = '0;
        seen = 0;
        for (int c = 0; c < 2 * FRAME + 100 && seen < 2; c++) begin
            @(negedge clk);
            done = '0;
            clear_req = (c == 100 || c == 5000);
            clear_colour = (c == 100) ? 3'b101 : 3'b110;
            plot_in = 4'($urandom);
            if (clear_done) seen++;
        end
        clear_req = 1'b0;
        chk("clear_done_pulses", 32'(seen), 2);
        repeat (5) @(negedge clk);

        // Reset in the middle of a sweep at pixel (80,60).
        clear_req = 1'b1; clear_colour = 3'b111;
        @(negedge clk); clear_req = 1'b0;
        hit = 0;
        for (int c = 0; c < FRAME && !hit; c++) begin
            @(negedge clk);
            hit = plot_out && x_out == 8'd80 && y_out == 7'd60;
        end
        chk("reach_pixel_80_60", 32'(hit), 1);
        #1 reset = 1'b1;
        #1 check_zero_outputs("async_reset");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);

        // Randomized traffic with spurious done pulses on losers.
        repeat (300) begin @(negedge clk); step_engines(1, 0, 0); end
        @(negedge clk); req = '0; done = '0;
        repeat (6) @(negedge clk);
        chk("pixel_queue_drained", 32'(pix_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
